lsu_axi: RTL and testbench
==========================

# lsu_axi

Parametrised load/store unit: the next-generation memory path of the core's execute stage. Accepts one load or store request at a time and issues a single-beat AXI4 transaction. Handles byte-lane placement on a wide data bus, write-strobe generation, sign/zero extension, misalignment trapping and AXI error responses, then returns one result pulse to writeback.

## Interface
- XLEN, 32: register width in bits (32 or 64).
- AXI_DATA_W, 512: AXI data bus width in bits, power of two, ≥ XLEN.
- ADDR_W, 29: AXI address width.
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  in  1  loads only: sign-extend when 1.
- req_addr  in  32  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  destination register tag.
- resp_valid  out  1  one-cycle result pulse.
- resp_data  out  XLEN  load result; 0 for stores and on errors.
- resp_rd  out  5  tag of the completed request.
- resp_wen  out  1  register write enable; 1 only for an error-free load.
- resp_err  out  1  misaligned access, unsupported size, or AXI SLVERR/DECERR.
- araddr/awaddr  out  ADDR_W  transaction address.
- arsize/awsize  out  3  {1'b0, req_size}.
- arvalid, rready, awvalid, wvalid, wlast, bready  out  1  AXI handshakes.
- arready, rvalid, rlast, awready, wready, bvalid  in  1  AXI handshakes.
- rdata  in  AXI_DATA_W; rresp/bresp  in  2.
- wdata  out  AXI_DATA_W; wstrb  out  AXI_DATA_W/8.
- Constant attributes (len 0, burst INCR, cache 4'b0011, id/lock/prot/qos 0) are tied at the top level and are not ports of this block.

## Operation
- States: IDLE, LOAD, STORE, RESP. req_ready = (state == IDLE), combinational.
- Handshake: accept when req_valid && req_ready. Latch store flag, size, signed flag, address, wdata and rd.
- Pre-check at accept: misaligned (addr mod 2^size ≠ 0) or 2^size > XLEN/8 → go to RESP with resp_err = 1. No bus activity.
- LOAD:
  - Assert arvalid and rready together, with araddr = addr[ADDR_W-1:0].
  - Drop arvalid on arready; drop rready on rvalid.
  - On rvalid, capture the data and go to RESP.
- Lane extraction for loads:
  - off = addr[log2(AXI_DATA_W/8)-1:0].
  - Take bytes off .. off+2^size-1 of rdata.
  - Zero-extend, or sign-extend from the top byte taken when req_signed = 1.
- STORE:
  - Assert awvalid, wvalid, wlast and bready together.
  - wdata = low 2^size bytes of req_wdata shifted left by off*8, other bits 0.
  - wstrb = ((1<<2^size)-1) << off.
  - awvalid and wvalid drop independently on their own ready; wlast falls with wvalid.
  - Go to RESP on bvalid. The unit does not wait for bvalid before both AW and W are accepted; bvalid arriving earlier is ignored.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_err = rresp[1] or bresp[1] (OKAY/EXOKAY = 0).
  - On an error, resp_data = 0 and resp_wen = 0.
- Reset mid-operation:
  - All AXI valid/ready outputs return to 0 next cycle and state goes to IDLE.
  - The in-flight transaction is abandoned; the interconnect shares rstn.
- Reset values:
  - arvalid, rready, awvalid, wvalid, wlast, bready, resp_valid, resp_wen, resp_err = 0.
  - araddr, awaddr, wdata, wstrb, resp_data, resp_rd = 0.
  - arsize = awsize = 3'b010.

## Timing
- All outputs except req_ready are registered.
- Load with zero-wait slave: accept in cycle 0; arvalid/rready in cycle 1 (arready = 1); rvalid in cycle 2; resp_valid in cycle 3; req_ready in cycle 4.
- Store with zero-wait slave: same schedule, with AW/W in cycle 1 and B in cycle 2.
- Sustained throughput: one request per 4 cycles.
- Error pre-check: accept in cycle 0, resp_valid in cycle 1, req_ready in cycle 2.
- Each slave wait cycle on any channel adds exactly one cycle of latency.

## Test plan
- LB signed, addr 0x43, rdata byte 3 = 0x80, rd = 5 → araddr 0x43, arsize 0; resp_data 0xFFFFFF80, resp_rd 5, resp_wen 1 in cycle 3.
- LHU, addr 0x3E, rdata[511:496] = 0x8001 → resp_data 0x00008001; LH at the same address → 0xFFFF8001.
- SH, addr 0x3E, wdata 0x1234ABCD → awsize 1, wstrb 64'hC000_0000_0000_0000, wdata[511:496] = 0xABCD, all other bits 0.
- LW at addr 0x102 → resp_err 1 and resp_wen 0 in cycle 1; arvalid never rises.
- SW, wready immediate, awready delayed 3 cycles, bresp 2'b10 → wvalid low after 1 cycle while awvalid is held 4 cycles; resp_err 1.
- rstn low for 1 cycle while in LOAD with arvalid high → arvalid and rready 0, req_ready 1 next cycle; a new LW then completes normally.

Source files
------------

// File: rtl/lsu_axi.sv
// -----------------------------------------------------------------------------
// lsu_axi -- single-outstanding load/store unit with a single-beat AXI4 master.
//
// Accepts one load or store at a time, places bytes on a wide AXI data bus,
// generates write strobes, sign/zero-extends loads, traps misaligned or
// unsupported-size accesses without touching the bus, and reports AXI
// SLVERR/DECERR.  Exactly one resp_valid pulse is produced per request.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid/req_ready       request handshake (req_ready = unit idle)
//   req_store, req_size,      store flag, log2(bytes), sign-extend flag,
//   req_signed, req_addr,     byte address, right-aligned store data,
//   req_wdata, req_rd         destination register tag
//   resp_valid, resp_data,    one-cycle result pulse, load data,
//   resp_rd, resp_wen,        tag, register write enable,
//   resp_err                  misaligned/unsupported/AXI error
//   ar*/r*                    AXI read address / read data channels
//   aw*/w*/b*                 AXI write address / data / response channels
// -----------------------------------------------------------------------------
module lsu_axi #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned AXI_DATA_W = 512,
   parameter int unsigned ADDR_W     = 29
) (
   input  logic                    clk,
   input  logic                    rstn,
   // request
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_store,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [31:0]             req_addr,
   input  logic [XLEN-1:0]         req_wdata,
   input  logic [4:0]              req_rd,
   // response
   output logic                    resp_valid,
   output logic [XLEN-1:0]         resp_data,
   output logic [4:0]              resp_rd,
   output logic                    resp_wen,
   output logic                    resp_err,
   // AXI read address / data
   output logic [ADDR_W-1:0]       araddr,
   output logic [2:0]              arsize,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [AXI_DATA_W-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   // AXI write address / data / response
   output logic [ADDR_W-1:0]       awaddr,
   output logic [2:0]              awsize,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [AXI_DATA_W-1:0]   wdata,
   output logic [AXI_DATA_W/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int unsigned STRB_W = AXI_DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   // highest bit that can hold a load sign bit (dword top, clipped to the bus)
   localparam int unsigned TOP_D  = (AXI_DATA_W < 64) ? AXI_DATA_W - 1 : 63;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;

   state_t                  state_q;
   logic [OFF_W-1:0]        off_q;
   logic [1:0]              size_q;
   logic                    signed_q;
   logic [4:0]              rd_q;

   logic                    arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
   logic [ADDR_W-1:0]       araddr_q, awaddr_q;
   logic [2:0]              arsize_q, awsize_q;
   logic [AXI_DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic                    resp_valid_q, resp_wen_q, resp_err_q;
   logic [XLEN-1:0]         resp_data_q;
   logic [4:0]              resp_rd_q;

   // ---------------------------------------------------------------- pre-check
   logic [3:0]              nbytes_req;
   logic                    misalign;
   logic                    precheck_err;

   assign nbytes_req = 4'd1 << req_size;

   always_comb begin
      misalign = 1'b0;
      unique case (req_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = req_addr[0];
         2'd2:    misalign = |req_addr[1:0];
         default: misalign = |req_addr[2:0];
      endcase
   end

   assign precheck_err = misalign || (32'(nbytes_req) > (XLEN / 8));

   // ---------------------------------------------------------- store placement
   logic [AXI_DATA_W-1:0]   wdata_masked, wdata_d;
   logic [STRB_W-1:0]       strb_base, wstrb_d;

   always_comb begin
      wdata_masked = '0;
      strb_base    = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         if (i < (32'd8 << req_size)) wdata_masked[i] = req_wdata[i];
      end
      for (int unsigned i = 0; i < STRB_W; i++) begin
         if (i < 32'(nbytes_req)) strb_base[i] = 1'b1;
      end
      wdata_d = wdata_masked << {req_addr[OFF_W-1:0], 3'b000};
      wstrb_d = strb_base << req_addr[OFF_W-1:0];
   end

   // ----------------------------------------------------------- load extraction
   logic [AXI_DATA_W-1:0]   rshift;
   logic [31:0]             lbits;
   logic                    sbit;
   logic [XLEN-1:0]         ldata_d;

   always_comb begin
      rshift = rdata >> {off_q, 3'b000};
      lbits  = 32'd8 << size_q;
      sbit   = 1'b0;
      unique case (size_q)
         2'd0:    sbit = rshift[7];
         2'd1:    sbit = rshift[15];
         2'd2:    sbit = rshift[31];
         default: sbit = rshift[TOP_D];
      endcase
      sbit    = sbit & signed_q;
      ldata_d = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         ldata_d[i] = (i < lbits) ? rshift[i] : sbit;
      end
   end

   // ---------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         off_q        <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         rd_q         <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         wlast_q      <= 1'b0;
         bready_q     <= 1'b0;
         araddr_q     <= '0;
         awaddr_q     <= '0;
         arsize_q     <= 3'b010;
         awsize_q     <= 3'b010;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_wen_q   <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  off_q    <= req_addr[OFF_W-1:0];
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  rd_q     <= req_rd;
                  if (precheck_err) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_wen_q   <= 1'b0;
                     resp_data_q  <= '0;
                     resp_rd_q    <= req_rd;
                  end else if (req_store) begin
                     state_q   <= S_STORE;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     wlast_q   <= 1'b1;
                     bready_q  <= 1'b1;
                     awaddr_q  <= req_addr[ADDR_W-1:0];
                     awsize_q  <= {1'b0, req_size};
                     wdata_q   <= wdata_d;
                     wstrb_q   <= wstrb_d;
                  end else begin
                     state_q   <= S_LOAD;
                     arvalid_q <= 1'b1;
                     rready_q  <= 1'b1;
                     araddr_q  <= req_addr[ADDR_W-1:0];
                     arsize_q  <= {1'b0, req_size};
                  end
               end
            end
            S_LOAD: begin
               if (arready) arvalid_q <= 1'b0;
               if (rvalid) begin
                  arvalid_q    <= 1'b0;
                  rready_q     <= 1'b0;
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= rresp[1];
                  resp_wen_q   <= !rresp[1];
                  resp_data_q  <= rresp[1] ? '0 : ldata_d;
                  resp_rd_q    <= rd_q;
               end
            end
            S_STORE: begin
               if (awready) awvalid_q <= 1'b0;
               if (wready) begin
                  wvalid_q <= 1'b0;
                  wlast_q  <= 1'b0;
               end
               // B only counts once both AW and W were accepted in earlier cycles
               if (bvalid && !awvalid_q && !wvalid_q) begin
                  bready_q     <= 1'b0;
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= bresp[1];
                  resp_wen_q   <= 1'b0;
                  resp_data_q  <= '0;
                  resp_rd_q    <= rd_q;
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               resp_wen_q   <= 1'b0;
               resp_err_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign awvalid    = awvalid_q;
   assign wvalid     = wvalid_q;
   assign wlast      = wlast_q;
   assign bready     = bready_q;
   assign araddr     = araddr_q;
   assign awaddr     = awaddr_q;
   assign arsize     = arsize_q;
   assign awsize     = awsize_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign resp_valid = resp_valid_q;
   assign resp_wen   = resp_wen_q;
   assign resp_err   = resp_err_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;

   logic unused_inputs;
   assign unused_inputs = ^{rlast, rresp[0], bresp[0], req_addr[31:ADDR_W], rshift};

endmodule

// File: tb/tb_lsu_axi.sv
module tb_lsu_axi;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned DW     = 512;
   localparam int unsigned AW     = 29;
   localparam int unsigned STRB_W = DW / 8;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req_valid, req_ready, req_store, req_signed;
   logic [1:0]        req_size;
   logic [31:0]       req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [4:0]        req_rd;
   logic              resp_valid, resp_wen, resp_err;
   logic [XLEN-1:0]   resp_data;
   logic [4:0]        resp_rd;
   logic [AW-1:0]     araddr, awaddr;
   logic [2:0]        arsize, awsize;
   logic              arvalid, arready, rvalid, rlast, rready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp, bresp;
   logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [DW-1:0]     wdata;
   logic [STRB_W-1:0] wstrb;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_axi #(.XLEN(XLEN), .AXI_DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_wen(resp_wen), .resp_err(resp_err),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
   endtask

   // Runs one request against a scripted slave. Called and returns at a negedge
   // with the unit idle. Cycle 0 is the accept cycle.
   task automatic run_txn(input string tag, input bit st, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [511:0] rd_data, input logic [1:0] rsp,
                          input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                          input int b_dly, input bit early_b);
      int unsigned nb, off;
      bit          bad, exp_err, got;
      int          exp_cyc, c, resp_c, mx;
      int          ar_seen, aw_seen, w_seen, rr_cnt, br_cnt, wlast_bad, busy_bad;
      int          ar_done_c, aw_done_c, w_done_c;
      bit          r_done, b_done;
      logic [63:0]  m, v, exp_strb;
      logic [511:0] sh, wm, exp_wd;
      logic [31:0]  exp_data;
      logic [31:0]  g_data;
      logic [4:0]   g_rd;
      logic         g_err, g_wen;

      // reference model
      nb  = 1 << sz;
      off = addr % STRB_W;
      bad = ((addr % nb) != 0) || (nb > XLEN / 8);
      exp_err = bad || rsp[1];
      m = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
      sh = rd_data >> (8 * off);
      v = sh[63:0] & m;
      if (sgn && v[8*nb-1]) v = v | ~m;
      exp_data = (st || exp_err) ? 32'd0 : v[31:0];
      wm = '0;
      wm[63:0] = {32'd0, wd} & m;
      exp_wd = wm << (8 * off);
      exp_strb = ((64'd1 << nb) - 64'd1) << off;
      mx = (aw_dly > w_dly) ? aw_dly : w_dly;
      exp_cyc = bad ? 1 : (st ? 3 + mx + b_dly : 3 + ar_dly + r_dly);

      ar_seen = 0; aw_seen = 0; w_seen = 0; rr_cnt = 0; br_cnt = 0;
      wlast_bad = 0; busy_bad = 0; ar_done_c = 0; aw_done_c = 0; w_done_c = 0;
      r_done = 0; b_done = 0; got = 0; resp_c = -1;
      g_data = 'x; g_rd = 'x; g_err = 'x; g_wen = 'x;

      check({tag, ":req_ready_idle"}, req_ready, 1'b1);
      req_valid = 1; req_store = st; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd; req_rd = rd;
      @(negedge clk);
      req_valid = 0; req_store = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
      c = 1;
      while (!got && c < 60) begin
         if (req_ready !== 1'b0) busy_bad++;
         if (wlast !== wvalid) wlast_bad++;
         if (rready) rr_cnt++;
         if (bready) br_cnt++;
         if (arvalid) begin
            ar_seen++;
            if (ar_seen == 1) begin
               check({tag, ":araddr"}, araddr, addr[AW-1:0]);
               check({tag, ":arsize"}, arsize, {1'b0, sz});
            end
         end
         if (awvalid) begin
            aw_seen++;
            if (aw_seen == 1) begin
               check({tag, ":awaddr"}, awaddr, addr[AW-1:0]);
               check({tag, ":awsize"}, awsize, {1'b0, sz});
            end
         end
         if (wvalid) begin
            w_seen++;
            if (w_seen == 1) begin
               check({tag, ":wdata"}, wdata, exp_wd);
               check({tag, ":wstrb"}, wstrb, exp_strb);
            end
         end
         if (resp_valid) begin
            got = 1; resp_c = c;
            g_data = resp_data; g_rd = resp_rd; g_err = resp_err; g_wen = resp_wen;
            slave_idle();
         end else begin
            slave_idle();
            arready = arvalid && (ar_seen > ar_dly);
            if (arvalid && arready) ar_done_c = c;
            if (!st && ar_done_c > 0 && c > ar_done_c + r_dly && !r_done) begin
               rvalid = 1; rlast = 1; rdata = rd_data; rresp = rsp;
               if (rready) r_done = 1;
            end
            awready = awvalid && (aw_seen > aw_dly);
            wready  = wvalid && (w_seen > w_dly);
            if (awvalid && awready) aw_done_c = c;
            if (wvalid && wready) w_done_c = c;
            if (st && aw_done_c > 0 && w_done_c > 0 &&
                c > ((aw_done_c > w_done_c) ? aw_done_c : w_done_c) + b_dly && !b_done) begin
               bvalid = 1; bresp = rsp;
               if (bready) b_done = 1;
            end else if (st && early_b && aw_done_c == 0 && w_done_c > 0) begin
               // premature response while AW is outstanding: must be ignored
               bvalid = 1; bresp = 2'b10;
            end
            @(negedge clk);
            c++;
         end
      end
      check({tag, ":resp_seen"}, got, 1'b1);
      check({tag, ":resp_cycle"}, resp_c, exp_cyc);
      check({tag, ":resp_data"}, g_data, exp_data);
      check({tag, ":resp_rd"}, g_rd, rd);
      check({tag, ":resp_err"}, g_err, exp_err);
      check({tag, ":resp_wen"}, g_wen, !st && !exp_err);
      check({tag, ":ar_cycles"}, ar_seen, (!st && !bad) ? ar_dly + 1 : 0);
      check({tag, ":aw_cycles"}, aw_seen, (st && !bad) ? aw_dly + 1 : 0);
      check({tag, ":w_cycles"}, w_seen, (st && !bad) ? w_dly + 1 : 0);
      check({tag, ":rready_cycles"}, rr_cnt, (!st && !bad) ? exp_cyc - 1 : 0);
      check({tag, ":bready_cycles"}, br_cnt, (st && !bad) ? exp_cyc - 1 : 0);
      check({tag, ":wlast_follows_wvalid"}, wlast_bad, 0);
      check({tag, ":req_ready_busy"}, busy_bad, 0);
      @(negedge clk);
      check({tag, ":resp_one_cycle"}, resp_valid, 1'b0);
      check({tag, ":req_ready_after"}, req_ready, 1'b1);
      check({tag, ":bus_quiet"}, {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
   endtask

   initial begin
      logic [511:0] rd_data;
      logic [31:0]  a;
      logic [1:0]   sz, rsp;
      bit           st;

      rstn = 0;
      req_valid = 0; req_store = 0; req_size = 0; req_signed = 0;
      req_addr = 0; req_wdata = 0; req_rd = 0;
      slave_idle();
      repeat (3) @(negedge clk);

      // reset values
      check("rst:req_ready", req_ready, 1'b1);
      check("rst:handshakes", {arvalid, rready, awvalid, wvalid, wlast, bready}, 6'b0);
      check("rst:resp_flags", {resp_valid, resp_wen, resp_err}, 3'b0);
      check("rst:araddr", araddr, 0);
      check("rst:awaddr", awaddr, 0);
      check("rst:wdata", wdata, 0);
      check("rst:wstrb", wstrb, 0);
      check("rst:resp_data", resp_data, 0);
      check("rst:resp_rd", resp_rd, 0);
      check("rst:arsize", arsize, 3'b010);
      check("rst:awsize", awsize, 3'b010);
      rstn = 1;
      @(negedge clk);

      // directed cases
      rd_data = 512'h80 << 24;
      run_txn("lb_signed", 0, 2'd0, 1, 32'h43, 0, 5'd5, rd_data, 2'b00, 0, 0, 0, 0, 0, 0);
      rd_data = {16'h8001, 496'd0};
      run_txn("lhu", 0, 2'd1, 0, 32'h3E, 0, 5'd7, rd_data, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("lh", 0, 2'd1, 1, 32'h3E, 0, 5'd8, rd_data, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("sh", 1, 2'd1, 0, 32'h3E, 32'h1234ABCD, 5'd9, '0, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("lw_misaligned", 0, 2'd2, 0, 32'h102, 0, 5'd10, '1, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("ld_unsupported", 0, 2'd3, 0, 32'h108, 0, 5'd11, '1, 2'b00, 0, 0, 0, 0, 0, 0);
      run_txn("sw_aw_wait_slverr", 1, 2'd2, 0, 32'h80, 32'hDEADBEEF, 5'd12, '0, 2'b10, 0, 0, 3, 0, 0, 0);
      run_txn("sw_early_b", 1, 2'd2, 0, 32'h84, 32'hCAFEF00D, 5'd13, '0, 2'b00, 0, 0, 2, 0, 1, 1);
      rd_data = {16{32'h89ABCDEF}};
      run_txn("lw_decerr", 0, 2'd2, 0, 32'h200, 0, 5'd14, rd_data, 2'b11, 1, 2, 0, 0, 0, 0);

      // reset while a load is waiting on arready
      req_valid = 1; req_store = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h100; req_rd = 5'd3;
      @(negedge clk);
      req_valid = 0;
      check("midrst:arvalid_before", arvalid, 1'b1);
      rstn = 0;
      @(negedge clk);
      check("midrst:arvalid", arvalid, 1'b0);
      check("midrst:rready", rready, 1'b0);
      check("midrst:req_ready", req_ready, 1'b1);
      rstn = 1;
      rd_data = 512'h1122_3344 << (8 * 32'h10);
      run_txn("lw_after_reset", 0, 2'd2, 0, 32'h110, 0, 5'd4, rd_data, 2'b00, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 16; i++) rd_data[i*32 +: 32] = $urandom;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         st = 1'($urandom_range(0, 1));
         rsp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         run_txn("rand", st, sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
                 rd_data, rsp, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
